// File: rtl/cam_writer_pkg.sv
// Shared types and defaults for the camera frame writer.
package cam_writer_pkg;
    localparam int unsigned ADDR_W      = 25;
    localparam int unsigned PIX_W       = 10;
    localparam int unsigned DEF_FRAME_W = 640;
    localparam int unsigned DEF_FRAME_H = 480;

    typedef enum logic [1:0] {IDLE, ARMED, WAIT_LINE, LINE} cam_state_e;
endpackage

// File: rtl/cam_addr_gen.sv
// Pixel position counters, line-base accumulator, buffer select and
// end-of-frame detection for the camera frame writer.
module cam_addr_gen
    import cam_writer_pkg::*;
#(
    parameter int unsigned       FRAME_W = DEF_FRAME_W,
    parameter int unsigned       FRAME_H = DEF_FRAME_H,
    parameter logic [ADDR_W-1:0] BASE0   = 25'd0,
    parameter logic [ADDR_W-1:0] BASE1   = 25'd307200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic              swap,
    input  logic              line_start,
    input  logic              in_line,
    input  logic              pix_en,
    input  logic              test_mode,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              hit,
    output logic              eof,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [PIX_W-1:0]  pix_din,
    output logic [ADDR_W-1:0] wbuf
);
    localparam int unsigned XW = $clog2(FRAME_W + 1);
    localparam int unsigned YW = $clog2(FRAME_H + 1);
    localparam logic [XW-1:0] X_END  = XW'(FRAME_W);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

    logic [XW-1:0]     x_q, px;
    logic [YW-1:0]     y_q, py;
    logic [ADDR_W-1:0] base_q, lbase;
    logic              wsel_q, ls_step;

    assign wbuf = wsel_q ? BASE1 : BASE0;

    // A line_start on the last line is ignored, so the pixel keeps its column.
    assign ls_step = line_start && in_line && (y_q != Y_LAST);

    always_comb begin
        px       = ls_step ? '0 : x_q;
        py       = ls_step ? y_q + YW'(1) : y_q;
        lbase    = ls_step ? base_q + ADDR_W'(FRAME_W) : base_q;
        hit      = pix_en && (px < X_END);
        eof      = hit && (px == X_LAST) && (py == Y_LAST);
        pix_addr = lbase + ADDR_W'(px);
        pix_din  = test_mode ? {5'(px), 5'(py)} : pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            base_q <= BASE0;
            wsel_q <= 1'b0;
        end else begin
            if (swap) wsel_q <= ~wsel_q;
            if (clear) begin
                x_q    <= '0;
                y_q    <= '0;
                base_q <= wbuf;
            end else if (step) begin
                if (ls_step) begin
                    y_q    <= py;
                    base_q <= lbase;
                end
                x_q <= hit ? px + XW'(1) : px;
            end
        end
    end
endmodule

// File: rtl/cam_frame_writer.sv
// Camera pixel stream to double-buffered SDRAM write port.
// Define CAM_TEST_PATTERN_EN to add a test_mode input that writes {x,y} pattern data.
module cam_frame_writer
    import cam_writer_pkg::*;
#(
    parameter int unsigned       FRAME_W = DEF_FRAME_W,
    parameter int unsigned       FRAME_H = DEF_FRAME_H,
    parameter logic [ADDR_W-1:0] BASE0   = 25'd0,
    parameter logic [ADDR_W-1:0] BASE1   = 25'd307200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              fifo_full,
`ifdef CAM_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              portC_write,
    output logic [ADDR_W-1:0] portC_addr,
    output logic [PIX_W-1:0]  portC_din,
    output logic [ADDR_W-1:0] read_offset,
    output logic              frame_done,
    output logic              overflow,
    output logic [7:0]        frames_dropped
);
    cam_state_e        state_q, state_d;
    logic              active, in_line, pix_en, accept, tm;
    logic              clear, step, swap, drop_inc;
    logic              hit, eof;
    logic [ADDR_W-1:0] pix_addr, wbuf;
    logic [PIX_W-1:0]  pix_din;

`ifdef CAM_TEST_PATTERN_EN
    assign tm = test_mode;
`else
    assign tm = 1'b0;
`endif

    assign active  = enable && (state_q != IDLE);
    assign in_line = active && (state_q == LINE);
    assign pix_en  = pix_valid && (in_line || (active && state_q == WAIT_LINE && line_start));
    // The frame-ending pixel survives a coincident frame_start; any other pixel loses to it.
    assign accept  = hit && (!frame_start || eof);

    cam_addr_gen #(
        .FRAME_W(FRAME_W),
        .FRAME_H(FRAME_H),
        .BASE0  (BASE0),
        .BASE1  (BASE1)
    ) u_addr (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (clear),
        .step      (step),
        .swap      (swap),
        .line_start(line_start),
        .in_line   (in_line),
        .pix_en    (pix_en),
        .test_mode (tm),
        .pix_data  (pix_data),
        .hit       (hit),
        .eof       (eof),
        .pix_addr  (pix_addr),
        .pix_din   (pix_din),
        .wbuf      (wbuf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        step     = 1'b0;
        swap     = 1'b0;
        drop_inc = 1'b0;
        if (state_q == IDLE) begin
            if (enable) state_d = ARMED;
        end else if (!enable) begin
            state_d = IDLE;
        end else if (state_q == ARMED) begin
            if (frame_start) begin
                clear   = 1'b1;
                state_d = line_start ? LINE : WAIT_LINE;
            end
        end else if (eof) begin
            swap    = 1'b1;
            state_d = ARMED;
        end else if (frame_start) begin
            clear    = 1'b1;
            drop_inc = 1'b1;
            state_d  = line_start ? LINE : WAIT_LINE;
        end else begin
            step = 1'b1;
            if (line_start) state_d = LINE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            portC_write    <= 1'b0;
            portC_addr     <= '0;
            portC_din      <= '0;
            read_offset    <= BASE1;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
            frames_dropped <= '0;
        end else begin
            portC_write <= accept && !fifo_full;
            if (accept && !fifo_full) begin
                portC_addr <= pix_addr;
                portC_din  <= pix_din;
            end
            if (accept && fifo_full) overflow <= 1'b1;
            frame_done <= eof;
            if (eof) read_offset <= wbuf;
            if (drop_inc && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
        end
    end
endmodule
